out_wr_dma: RTL and testbench
=============================

Name: out_wr_dma

Overview:
AXI4 write-only DMA that drains the 32-bit result BRAM into DDR once a layer finishes. It is the write-direction counterpart of the sparse-weight read DMA. It sits between the accumulator output BRAM and axi_dma_bridge, and uses its own stream ID. It packs two 32-bit entries per 64-bit beat, issues INCR bursts that never cross a 4 KB page, and reports done/error to the CSR block.

Parameters:
AXI_ADDR_W, 32, AXI address width
AXI_DATA_W, 64, AXI data width (fixed 64; other values unsupported)
AXI_ID_W, 4, AXI ID width
STREAM_ID, 2, constant driven on awid
BRAM_ADDR_W, 10, result BRAM word-address width
BURST_LEN, 8'd15, maximum awlen (16 beats = 128 bytes)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  level; a transfer begins on the first cycle seen high in IDLE
dst_addr  in  AXI_ADDR_W  DDR byte address, 8-byte aligned
csr_num_words  in  32  number of 32-bit results to write
done  out  1  held high in DONE, or for 1 cycle after error
busy  out  1  transfer in progress
error  out  1  sticky until the next start; set by bad bresp or oversize count
m_axi_awid  out  AXI_ID_W  STREAM_ID
m_axi_awaddr  out  AXI_ADDR_W  burst address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  3'b011
m_axi_awburst  out  2  2'b01
m_axi_awvalid / m_axi_awready  out/in  1  AW handshake
m_axi_wdata  out  64  packed results, entry n in [31:0], entry n+1 in [63:32]
m_axi_wstrb  out  8  byte enables
m_axi_wlast  out  1  last beat of burst
m_axi_wvalid / m_axi_wready  out/in  1  W handshake
m_axi_bid  in  AXI_ID_W  unused
m_axi_bresp  in  2  write response
m_axi_bvalid / m_axi_bready  in/out  1  B handshake
res_rd_en  out  1  BRAM read enable
res_rd_addr  out  BRAM_ADDR_W  BRAM word address
res_rd_data  in  32  BRAM data, valid 1 cycle after res_rd_en

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset mid-transfer abandons any outstanding AXI transaction with no drain. awid, awsize and awburst are constant.
- total_beats = ceil(num_words/2) = (num_words+1)>>1, computed in 32 bits. The BRAM word address starts at 0 and increments once per read.
- IDLE:
  - done=0.
  - On start: latch dst_addr and num_words, clear error, set busy=1.
  - If num_words==0, go to DONE.
  - If num_words > 2**BRAM_ADDR_W, set error=1, pulse done for 1 cycle, set busy=0, stay in IDLE.
  - Otherwise go to ISSUE_AW.
- start is ignored while busy.
- ISSUE_AW:
  - awlen = min(BURST_LEN, beats_left-1, page_beats-1), where page_beats = 512 - addr[11:3] (11-bit, 1..512).
  - awvalid is held until awready. Then load beat_cnt = awlen and go to FETCH_LO.
- FETCH_LO: assert res_rd_en at the next address, then go to FETCH_HI.
- FETCH_HI:
  - Capture the low word.
  - If another word remains, issue a second read and go to CAPTURE. Otherwise set the high half to 0 and go to SEND.
- CAPTURE: capture the high word, then go to SEND.
- SEND:
  - wvalid is held, and wdata/wstrb/wlast stay stable until wready.
  - wlast = (beat_cnt==0).
  - wstrb = 8'hFF. On a beat carrying only one valid word (odd num_words, final beat) wstrb = 8'h0F.
  - On the handshake: if wlast, go to WAIT_B. Otherwise decrement beat_cnt and go to FETCH_LO.
  - Throughput is 1 beat per 4 cycles with a zero-wait slave; this is accepted.
- WAIT_B:
  - bready=1.
  - On bvalid with bresp!=0: error=1, done pulses for 1 cycle, busy=0, go to IDLE.
  - On bvalid with OKAY: addr += (awlen+1)*8, beats_left -= awlen+1. If beats_left==0, go to DONE; otherwise go to ISSUE_AW.
- Only one burst is outstanding at a time. wvalid is never asserted before the AW of its burst has been accepted.
- DONE: busy=0 and done=1, held until start deasserts, then go to IDLE.
- Address crossing a 4 KB boundary: the burst is truncated at the page edge, and the next burst starts page-aligned at full length.

Decomposition:
- Shared package dma_pkg: AXI_SIZE_64, AXI_BURST_INCR, AXI_RESP_OKAY, the 4 KB page_beats function, and the state enum for this block.
- One sub-module, axi_burst_calc (combinational): takes addr, beats_left and BURST_LEN, returns awlen. It is reusable by the read DMAs.

Test Plan:
- 32 words, dst 0x1000, zero-wait slave -> one AW, awlen=15; 16 beats all wstrb FF; wlast on beat 16; DDR holds BRAM[0..31]; done and busy=0.
- 5 words -> awlen=2; beat 3 has wstrb 0F and data[63:32]=0; one B.
- dst 0x0FC0, 40 words -> bursts of awlen 7 at 0x0FC0 and awlen 11 at 0x1000; no 4 KB crossing.
- Random awready/wready/bvalid stalls over 100 words -> wdata stable while stalled; exactly 50 beats; DDR contents match.
- bresp=SLVERR on the 2nd burst of 64 words -> error=1, 1-cycle done pulse, no further AW, IDLE; a new start clears error.
- num_words=0 -> DONE with no AXI traffic. num_words=1025 -> immediate error. rst asserted mid-SEND -> all outputs 0 in the next cycle.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared DMA definitions: AXI encodings, 4 KB page helper and the write-DMA state set.
package dma_pkg;

  localparam logic [2:0] AXI_SIZE_64    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_ISSUE_AW,
    WR_FETCH_LO,
    WR_FETCH_HI,
    WR_CAPTURE,
    WR_SEND,
    WR_WAIT_B,
    WR_DONE
  } wr_state_e;

  // 8-byte beats left before the next 4 KB boundary (1..512).
  function automatic logic [10:0] page_beats(input logic [8:0] beat_off);
    return 11'd512 - {2'b00, beat_off};
  endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// Picks the longest INCR burst that respects the length cap, the remaining beats and the 4 KB page.
module axi_burst_calc
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       beats_left,
  input  logic [7:0]        max_len,
  output logic [7:0]        awlen_c
);

  logic [31:0] left_m1;
  logic [31:0] page_m1;
  logic        unused_addr_bits;

  always_comb begin
    left_m1 = beats_left - 32'd1;
    page_m1 = 32'(page_beats(addr[11:3])) - 32'd1;
    awlen_c = max_len;
    if (left_m1 < 32'(awlen_c)) awlen_c = left_m1[7:0];
    if (page_m1 < 32'(awlen_c)) awlen_c = page_m1[7:0];
  end

  assign unused_addr_bits = ^{addr[ADDR_W-1:12], addr[2:0]};

endmodule

// File: rtl/out_wr_dma.sv
// Result-BRAM to DDR write DMA: packs two 32-bit results per 64-bit beat, one AXI burst in flight.
module out_wr_dma
  import dma_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W  = 32,
  parameter int unsigned AXI_DATA_W  = 64,
  parameter int unsigned AXI_ID_W    = 4,
  parameter int unsigned STREAM_ID   = 2,
  parameter int unsigned BRAM_ADDR_W = 10,
  parameter logic [7:0]  BURST_LEN   = 8'd15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [AXI_ADDR_W-1:0]   dst_addr,
  input  logic [31:0]             csr_num_words,
  output logic                    done,
  output logic                    busy,
  output logic                    error,
  output logic [AXI_ID_W-1:0]     m_axi_awid,
  output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [AXI_DATA_W-1:0]   m_axi_wdata,
  output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [AXI_ID_W-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic                    res_rd_en,
  output logic [BRAM_ADDR_W-1:0]  res_rd_addr,
  input  logic [31:0]             res_rd_data
);

  localparam int unsigned WIDX_W    = BRAM_ADDR_W + 1;
  localparam int unsigned STRB_W    = AXI_DATA_W / 8;
  localparam logic [31:0] MAX_WORDS = 32'(2 ** BRAM_ADDR_W);

  wr_state_e         state;
  logic [AXI_ADDR_W-1:0] addr;
  logic [31:0]       beats_left;
  logic [WIDX_W-1:0] num_words_q;
  logic [WIDX_W-1:0] word_idx;
  logic [7:0]        beat_cnt;
  logic              hi_pending;
  logic              armed;
  logic [7:0]        awlen_c;
  logic [8:0]        burst_beats;
  logic              unused_bid;

  assign m_axi_awid    = AXI_ID_W'(STREAM_ID);
  assign m_axi_awsize  = AXI_SIZE_64;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign burst_beats   = 9'(m_axi_awlen) + 9'd1;
  assign unused_bid    = ^m_axi_bid;

  axi_burst_calc #(.ADDR_W(AXI_ADDR_W)) u_burst_calc (
    .addr       (addr),
    .beats_left (beats_left),
    .max_len    (BURST_LEN),
    .awlen_c    (awlen_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WR_IDLE;
      addr          <= '0;
      beats_left    <= '0;
      num_words_q   <= '0;
      word_idx      <= '0;
      beat_cnt      <= '0;
      hi_pending    <= 1'b0;
      armed         <= 1'b1;
      done          <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wlast   <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      res_rd_en     <= 1'b0;
      res_rd_addr   <= '0;
    end else begin
      // A held start launches one transfer; it must drop before the next one.
      if (!start) armed <= 1'b1;

      case (state)
        WR_IDLE: begin
          done <= 1'b0;
          if (start && armed) begin
            armed       <= 1'b0;
            error       <= 1'b0;
            addr        <= dst_addr;
            beats_left  <= (csr_num_words + 32'd1) >> 1;
            num_words_q <= WIDX_W'(csr_num_words);
            word_idx    <= '0;
            if (csr_num_words == 32'd0) begin
              done  <= 1'b1;
              state <= WR_DONE;
            end else if (csr_num_words > MAX_WORDS) begin
              error <= 1'b1;
              done  <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= WR_ISSUE_AW;
            end
          end
        end

        WR_ISSUE_AW: begin
          if (!m_axi_awvalid) begin
            m_axi_awvalid <= 1'b1;
            m_axi_awaddr  <= addr;
            m_axi_awlen   <= awlen_c;
          end else if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            beat_cnt      <= m_axi_awlen;
            res_rd_en     <= 1'b1;
            res_rd_addr   <= BRAM_ADDR_W'(word_idx);
            word_idx      <= word_idx + WIDX_W'(1);
            state         <= WR_FETCH_LO;
          end
        end

        // Second read is launched here so its data lands in CAPTURE.
        WR_FETCH_LO: begin
          if (word_idx < num_words_q) begin
            res_rd_en   <= 1'b1;
            res_rd_addr <= BRAM_ADDR_W'(word_idx);
            word_idx    <= word_idx + WIDX_W'(1);
            hi_pending  <= 1'b1;
          end else begin
            res_rd_en  <= 1'b0;
            hi_pending <= 1'b0;
          end
          state <= WR_FETCH_HI;
        end

        WR_FETCH_HI: begin
          res_rd_en   <= 1'b0;
          m_axi_wdata <= AXI_DATA_W'(res_rd_data);
          if (hi_pending) begin
            state <= WR_CAPTURE;
          end else begin
            m_axi_wstrb  <= {{(STRB_W/2){1'b0}}, {(STRB_W/2){1'b1}}};
            m_axi_wlast  <= (beat_cnt == 8'd0);
            m_axi_wvalid <= 1'b1;
            state        <= WR_SEND;
          end
        end

        WR_CAPTURE: begin
          m_axi_wdata[AXI_DATA_W-1 -: 32] <= res_rd_data;
          m_axi_wstrb  <= '1;
          m_axi_wlast  <= (beat_cnt == 8'd0);
          m_axi_wvalid <= 1'b1;
          state        <= WR_SEND;
        end

        WR_SEND: begin
          if (m_axi_wready) begin
            m_axi_wvalid <= 1'b0;
            m_axi_wlast  <= 1'b0;
            if (m_axi_wlast) begin
              m_axi_bready <= 1'b1;
              state        <= WR_WAIT_B;
            end else begin
              beat_cnt    <= beat_cnt - 8'd1;
              res_rd_en   <= 1'b1;
              res_rd_addr <= BRAM_ADDR_W'(word_idx);
              word_idx    <= word_idx + WIDX_W'(1);
              state       <= WR_FETCH_LO;
            end
          end
        end

        WR_WAIT_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != AXI_RESP_OKAY) begin
              error <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= WR_IDLE;
            end else begin
              addr       <= addr + AXI_ADDR_W'({burst_beats, 3'b000});
              beats_left <= beats_left - 32'(burst_beats);
              if (beats_left == 32'(burst_beats)) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= WR_DONE;
              end else begin
                state <= WR_ISSUE_AW;
              end
            end
          end
        end

        WR_DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= WR_IDLE;
          end
        end

        default: state <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_wr_dma.sv
// Scoreboard bench for out_wr_dma: randomized AXI slave and BRAM model, expectations from a burst-splitting reference.
module tb_out_wr_dma;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_exp_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dst_addr = '0;
  logic [31:0] csr_num_words = '0;
  logic        done, busy, error;
  logic [3:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [3:0]  m_axi_bid = 4'd2;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic        res_rd_en;
  logic [9:0]  res_rd_addr;
  logic [31:0] res_rd_data = '0;

  aw_exp_t     exp_aw[$];
  w_exp_t      exp_w[$];
  logic [31:0] mem[1024];
  logic [31:0] ddr[int unsigned];

  int checks = 0;
  int errors = 0;
  int aw_stall = 0, w_stall = 0, b_stall = 0;
  int err_burst = -1;
  int aw_cnt = 0, b_cnt = 0, wlast_cnt = 0;
  int b_pending = 0, b_sent = 0, beats_seen = 0;
  bit b_fire = 1'b0;
  bit stall_seen = 1'b0;
  logic [63:0] st_data;
  logic [7:0]  st_strb;
  logic        st_last;
  logic [31:0] cur_addr = '0;

  always #5 clk = ~clk;

  out_wr_dma dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .dst_addr      (dst_addr),
    .csr_num_words (csr_num_words),
    .done          (done),
    .busy          (busy),
    .error         (error),
    .m_axi_awid    (m_axi_awid),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bid     (m_axi_bid),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .res_rd_en     (res_rd_en),
    .res_rd_addr   (res_rd_addr),
    .res_rd_data   (res_rd_data)
  );

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  function automatic void chk_wide(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // One-cycle BRAM latency; junk when not reading so late captures show up.
  always @(posedge clk) res_rd_data <= res_rd_en ? mem[res_rd_addr] : $urandom;

  // AXI slave + monitor: decisions made on the falling edge take effect at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_bresp   = 2'b00;
      b_fire = 1'b0; stall_seen = 1'b0;
      b_pending = 0; aw_cnt = 0; b_cnt = 0; wlast_cnt = 0;
      exp_aw.delete();
      exp_w.delete();
    end else begin
      if (b_fire) begin
        m_axi_bvalid = 1'b0;
        b_fire = 1'b0;
      end
      if (!m_axi_bvalid && b_pending > 0 && $urandom_range(0, 99) >= b_stall) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (b_sent == err_burst) ? 2'b10 : 2'b00;
        b_sent++;
        b_pending--;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_fire = 1'b1;
        b_cnt++;
      end

      m_axi_awready = ($urandom_range(0, 99) >= aw_stall);
      if (m_axi_awvalid && m_axi_awready) begin
        if (exp_aw.size() == 0) begin
          chk("aw_unexpected", 1, 0);
        end else begin
          aw_exp_t e;
          e = exp_aw.pop_front();
          chk_wide("aw_req", 128'({m_axi_awaddr, m_axi_awlen, aw_cnt == b_cnt}),
                   128'({e.addr, e.len, 1'b1}));
        end
        cur_addr = m_axi_awaddr;
        aw_cnt++;
      end

      if (stall_seen)
        chk_wide("w_stall_stable", 128'({m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast}),
                 128'({1'b1, st_data, st_strb, st_last}));
      m_axi_wready = ($urandom_range(0, 99) >= w_stall);
      stall_seen = m_axi_wvalid && !m_axi_wready;
      st_data = m_axi_wdata;
      st_strb = m_axi_wstrb;
      st_last = m_axi_wlast;
      if (m_axi_wvalid && m_axi_wready) begin
        if (exp_w.size() == 0) begin
          chk("w_unexpected", 1, 0);
        end else begin
          w_exp_t e;
          e = exp_w.pop_front();
          chk_wide("w_beat", 128'({m_axi_wdata, m_axi_wstrb, m_axi_wlast, aw_cnt > wlast_cnt}),
                   128'({e.data, e.strb, e.last, 1'b1}));
        end
        if (m_axi_wstrb[3:0] == 4'hF) ddr[cur_addr / 4] = m_axi_wdata[31:0];
        if (m_axi_wstrb[7:4] == 4'hF) ddr[cur_addr / 4 + 1] = m_axi_wdata[63:32];
        cur_addr += 32'd8;
        beats_seen++;
        if (m_axi_wlast) begin
          b_pending++;
          wlast_cnt++;
        end
      end
    end
  end

  // Reference: split the beat stream into bursts of at most 16 beats that stop at each 4 KB page edge.
  task automatic build_exp(input logic [31:0] dst, input int n, input int eb);
    int beats_left, word, len, page_left, burst;
    logic [31:0] a, lo, hi;
    ddr.delete();
    beats_seen = 0;
    b_sent = 0;
    err_burst = eb;
    beats_left = (n + 1) / 2;
    a = dst;
    word = 0;
    burst = 0;
    if (n <= 1024) begin
      while (beats_left > 0) begin
        page_left = (4096 - int'(a % 4096)) / 8;
        len = 16;
        if (beats_left < len) len = beats_left;
        if (page_left < len) len = page_left;
        exp_aw.push_back('{addr: a, len: 8'(len - 1)});
        for (int j = 0; j < len; j++) begin
          lo = mem[word];
          hi = (word + 1 < n) ? mem[word + 1] : 32'h0;
          exp_w.push_back('{data: {hi, lo}, strb: (word + 1 < n) ? 8'hFF : 8'h0F, last: (j == len - 1)});
          word += 2;
        end
        a += 32'(len * 8);
        beats_left -= len;
        if (burst == eb) break;
        burst++;
      end
    end
  endtask

  task automatic run_xfer(input logic [31:0] dst, input int n, input int eb);
    int c, mism;
    bit expect_err;
    expect_err = (n > 1024) || (eb >= 0);
    build_exp(dst, n, eb);
    @(negedge clk);
    dst_addr = dst;
    csr_num_words = 32'(n);
    start = 1'b1;
    c = 0;
    while (!done && c < 30000) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", int'(done), 1);
    chk("busy_at_done", int'(busy), 0);
    chk("error_flag", int'(error), int'(expect_err));
    chk("aw_outstanding", exp_aw.size(), 0);
    chk("w_outstanding", exp_w.size(), 0);
    if (!expect_err) begin
      mism = 0;
      for (int i = 0; i < n; i++) begin
        int unsigned key;
        key = dst / 4 + 32'(i);
        if (!ddr.exists(key) || ddr[key] !== mem[i]) mism++;
      end
      chk("ddr_contents", mism, 0);
      chk("beat_count", beats_seen, (n + 1) / 2);
    end
    @(negedge clk);
    chk(expect_err ? "done_pulse_end" : "done_held", int'(done), int'(!expect_err));
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_done_low", int'(done), 0);
    chk("idle_busy_low", int'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, int'({done, busy, error, m_axi_awvalid, m_axi_wlast, m_axi_wvalid, m_axi_bready, res_rd_en}), 0);
    chk_wide({tag, "_addr"}, 128'({m_axi_awaddr, m_axi_awlen, res_rd_addr, m_axi_wstrb}), 128'(0));
    chk_wide({tag, "_wdata"}, 128'(m_axi_wdata), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [31:0] dst;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    chk("awid", int'(m_axi_awid), 2);
    chk("awsize", int'(m_axi_awsize), 3);
    chk("awburst", int'(m_axi_awburst), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_xfer(32'h0000_1000, 32, -1);
    run_xfer(32'h0000_2000, 5, -1);
    run_xfer(32'h0000_0FC0, 40, -1);

    aw_stall = 40; w_stall = 50; b_stall = 40;
    run_xfer(32'h0000_5008, 100, -1);

    aw_stall = 0; w_stall = 0; b_stall = 0;
    run_xfer(32'h0000_3000, 64, 1);
    run_xfer(32'h0000_4000, 0, -1);
    run_xfer(32'h0000_4000, 1025, -1);
    run_xfer(32'h0000_7FF8, 1024, -1);

    for (int k = 0; k < 5; k++) begin
      aw_stall = $urandom_range(0, 60);
      w_stall  = $urandom_range(0, 60);
      b_stall  = $urandom_range(0, 60);
      dst = (32'($urandom_range(0, 7)) << 12) | (32'($urandom_range(0, 511)) << 3);
      run_xfer(dst, $urandom_range(1, 300), -1);
    end

    // Reset while a beat is being presented.
    aw_stall = 0; w_stall = 70; b_stall = 0;
    build_exp(32'h0000_6000, 200, -1);
    @(negedge clk);
    dst_addr = 32'h0000_6000;
    csr_num_words = 32'd200;
    start = 1'b1;
    c = 0;
    while (!m_axi_wvalid && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("reach_send", int'(m_axi_wvalid), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    w_stall = 20;
    run_xfer(32'h0000_0100, 7, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
